// File: rtl/psimd_mem_pkg.sv
// ---------------------------------------------------------------------------
// psimd_mem_pkg
// Shared definitions for the PSIMD data-memory access unit.
//  - Lane geometry: a 64-bit memory word holds 4 DLFloat16 lanes.
//  - Default widths and limits used by the access unit, its address
//    generator and the bus interface.
//  - mau_state_t: access unit control states.
// ---------------------------------------------------------------------------
package psimd_mem_pkg;

   localparam int PSIMD_LANES    = 4;
   localparam int DLF_W          = 16;
   localparam int WORD_BYTES     = 8;
   localparam int WORD_DATA_W    = PSIMD_LANES * DLF_W;
   localparam int MEM_ADDR_W     = 32;
   localparam int MAX_BEATS_DEF  = 8;
   localparam int ADDR_LIMIT_DEF = 255;

   // Request word count field and beat index field widths.
   localparam int BEATS_W    = 4;
   localparam int BEAT_IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2,
      ERR    = 2'd3
   } mau_state_t;

endpackage

// File: rtl/psimd_mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// psimd_mem_access_unit_if
// Bundles everything the access unit exchanges with the outside world except
// clock and reset:
//  - request handshake from the execute stage (req_*)
//  - store data pull (st_data_in / st_data_pop)
//  - load return (ld_data_out / ld_data_valid / ld_beat_idx)
//  - completion pulses (done / error)
//  - 64-bit memory port (address, data_out_to_mem, mem_read, mem_write,
//    data_in_from_mem)
// Modports:
//  master : the access unit itself (initiator of memory accesses)
//  slave  : its environment (execute stage + data memory)
// ---------------------------------------------------------------------------
interface psimd_mem_access_unit_if
   import psimd_mem_pkg::*;
#(
   parameter int DATA_W = WORD_DATA_W,
   parameter int ADDR_W = MEM_ADDR_W
);

   // request side
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_is_store;
   logic [ADDR_W-1:0]     req_addr;
   logic [BEATS_W-1:0]    req_beats;
   logic [DATA_W-1:0]     st_data_in;
   logic                  st_data_pop;
   logic [DATA_W-1:0]     ld_data_out;
   logic                  ld_data_valid;
   logic [BEAT_IDX_W-1:0] ld_beat_idx;
   logic                  done;
   logic                  error;

   // memory side
   logic [ADDR_W-1:0]     address;
   logic [DATA_W-1:0]     data_out_to_mem;
   logic                  mem_read;
   logic                  mem_write;
   logic [DATA_W-1:0]     data_in_from_mem;

   modport master (
      input  req_valid, req_is_store, req_addr, req_beats, st_data_in,
      output req_ready, st_data_pop, ld_data_out, ld_data_valid, ld_beat_idx,
      output done, error,
      output address, data_out_to_mem, mem_read, mem_write,
      input  data_in_from_mem
   );

   modport slave (
      output req_valid, req_is_store, req_addr, req_beats, st_data_in,
      input  req_ready, st_data_pop, ld_data_out, ld_data_valid, ld_beat_idx,
      input  done, error,
      input  address, data_out_to_mem, mem_read, mem_write,
      output data_in_from_mem
   );

endinterface

// File: rtl/psimd_addr_gen.sv
// ---------------------------------------------------------------------------
// psimd_addr_gen
// Address generation for the access unit: holds the base address and beat
// counter of the active request and checks a new request for legality.
// Ports:
//  clk, rst   clock, synchronous active-high reset
//  start      load a new (legal) request: addr=req_addr, beat=0
//  step       advance to the next word (addr += 8, beat += 1)
//  clear      return addr/beat to 0 (end of request)
//  req_addr   start address of the offered request
//  req_beats  word count of the offered request
//  legal      offered request is legal (combinational)
//  addr       registered address of the current beat (0 when inactive)
//  beat       registered index of the current beat
//  last       current beat is the final one of the request
// ---------------------------------------------------------------------------
module psimd_addr_gen
   import psimd_mem_pkg::*;
#(
   parameter int ADDR_W     = MEM_ADDR_W,
   parameter int MAX_BEATS  = MAX_BEATS_DEF,
   parameter int ADDR_LIMIT = ADDR_LIMIT_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  step,
   input  logic                  clear,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [BEATS_W-1:0]    req_beats,
   output logic                  legal,
   output logic [ADDR_W-1:0]     addr,
   output logic [BEAT_IDX_W-1:0] beat,
   output logic                  last
);

   // Four extra bits so base + 8*(beats-1) can never wrap around.
   localparam int EXT_W = ADDR_W + 4;

   logic [EXT_W-1:0]      span;
   logic [EXT_W-1:0]      end_addr;
   logic [ADDR_W-1:0]     addr_reg;
   logic [BEAT_IDX_W-1:0] beat_reg;
   logic [BEATS_W-1:0]    beats_reg;

   // Byte offset of the last word; meaningless for beats==0, but that case is
   // rejected on its own below.
   always_comb begin
      span     = EXT_W'({req_beats - 4'd1, 3'b000});
      end_addr = {4'b0000, req_addr} + span;
      legal    = (req_addr[2:0] == 3'b000)
              && (req_beats != '0)
              && (req_beats <= BEATS_W'(MAX_BEATS))
              && (end_addr <= EXT_W'(ADDR_LIMIT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg  <= '0;
         beat_reg  <= '0;
         beats_reg <= '0;
      end else if (clear) begin
         addr_reg  <= '0;
         beat_reg  <= '0;
      end else if (start) begin
         addr_reg  <= req_addr;
         beat_reg  <= '0;
         beats_reg <= req_beats;
      end else if (step) begin
         addr_reg  <= addr_reg + ADDR_W'(WORD_BYTES);
         beat_reg  <= beat_reg + 1'b1;
      end
   end

   assign addr = addr_reg;
   assign beat = beat_reg;
   assign last = ({1'b0, beat_reg} == (beats_reg - 4'd1));

endmodule

// File: rtl/psimd_mem_access_unit.sv
// ---------------------------------------------------------------------------
// psimd_mem_access_unit
// Initiator side of the PSIMD data-memory interface. A vector load/store
// request of 1..MAX_BEATS consecutive 64-bit words is turned into one
// mem_read or mem_write strobe per cycle at base, base+8, ...
// Ports:
//  clk   clock, rising edge
//  rst   synchronous active-high reset (aborts any request in flight)
//  bus   psimd_mem_access_unit_if.master: request handshake, store data
//        pull, load return, done/error pulses and the memory port
// Timing (accept edge T, N beats):
//  beat k strobed in cycle T+1+k; load word k valid in cycle T+2+k;
//  done in cycle T+1+N together with the final load word; idle at T+2+N.
//  Illegal requests: error in cycle T+1, no strobes, idle at T+2.
// ---------------------------------------------------------------------------
module psimd_mem_access_unit
   import psimd_mem_pkg::*;
#(
   parameter int DATA_W     = WORD_DATA_W,
   parameter int ADDR_W     = MEM_ADDR_W,
   parameter int MAX_BEATS  = MAX_BEATS_DEF,
   parameter int ADDR_LIMIT = ADDR_LIMIT_DEF
)(
   input  logic                      clk,
   input  logic                      rst,
   psimd_mem_access_unit_if.master   bus
);

   mau_state_t state_reg, state_next;

   logic mem_read_reg,  mem_read_next;
   logic mem_write_reg, mem_write_next;
   logic done_reg,      done_next;
   logic error_reg,     error_next;

   logic [DATA_W-1:0]     ld_data_reg;
   logic                  ld_valid_reg;
   logic [BEAT_IDX_W-1:0] ld_idx_reg;

   logic                  ag_start;
   logic                  ag_step;
   logic                  ag_clear;
   logic                  ag_legal;
   logic [ADDR_W-1:0]     ag_addr;
   logic [BEAT_IDX_W-1:0] ag_beat;
   logic                  ag_last;

   psimd_addr_gen #(
      .ADDR_W     (ADDR_W),
      .MAX_BEATS  (MAX_BEATS),
      .ADDR_LIMIT (ADDR_LIMIT)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .start     (ag_start),
      .step      (ag_step),
      .clear     (ag_clear),
      .req_addr  (bus.req_addr),
      .req_beats (bus.req_beats),
      .legal     (ag_legal),
      .addr      (ag_addr),
      .beat      (ag_beat),
      .last      (ag_last)
   );

   // Next-state and next-strobe logic. Strobes are computed one cycle ahead
   // so that mem_read/mem_write leave the block straight from flops.
   always_comb begin
      state_next     = state_reg;
      mem_read_next  = mem_read_reg;
      mem_write_next = mem_write_reg;
      done_next      = 1'b0;
      error_next     = 1'b0;
      ag_start       = 1'b0;
      ag_step        = 1'b0;
      ag_clear       = 1'b0;

      case (state_reg)
         IDLE: begin
            // req_ready is high exactly in IDLE, so req_valid alone is the
            // handshake here.
            if (bus.req_valid) begin
               if (ag_legal) begin
                  state_next     = ACCESS;
                  ag_start       = 1'b1;
                  mem_read_next  = !bus.req_is_store;
                  mem_write_next = bus.req_is_store;
               end else begin
                  state_next = ERR;
                  error_next = 1'b1;
               end
            end
         end
         ACCESS: begin
            if (ag_last) begin
               state_next     = DONE;
               ag_clear       = 1'b1;
               mem_read_next  = 1'b0;
               mem_write_next = 1'b0;
               done_next      = 1'b1;
            end else begin
               ag_step = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
         done_reg      <= 1'b0;
         error_reg     <= 1'b0;
         ld_data_reg   <= '0;
         ld_valid_reg  <= 1'b0;
         ld_idx_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         mem_read_reg  <= mem_read_next;
         mem_write_reg <= mem_write_next;
         done_reg      <= done_next;
         error_reg     <= error_next;
         // Memory read data is combinational from address/mem_read, so it is
         // captured at the end of the strobe cycle; ld_data_out holds between
         // beats.
         ld_valid_reg  <= mem_read_reg;
         if (mem_read_reg) begin
            ld_data_reg <= bus.data_in_from_mem;
            ld_idx_reg  <= ag_beat;
         end
      end
   end

   // Store data passes straight through while mem_write is high and is
   // forced to zero otherwise, lane by lane.
   wire [DATA_W-1:0] st_gated;

   genvar gi;
   generate
      for (gi = 0; gi < PSIMD_LANES; gi = gi + 1) begin : g_lane
         assign st_gated[gi*DLF_W +: DLF_W] =
            mem_write_reg ? bus.st_data_in[gi*DLF_W +: DLF_W] : {DLF_W{1'b0}};
      end
   endgenerate

   assign bus.req_ready       = (state_reg == IDLE);
   assign bus.st_data_pop     = mem_write_reg;
   assign bus.ld_data_out     = ld_data_reg;
   assign bus.ld_data_valid   = ld_valid_reg;
   assign bus.ld_beat_idx     = ld_idx_reg;
   assign bus.done            = done_reg;
   assign bus.error           = error_reg;
   assign bus.address         = ag_addr;
   assign bus.data_out_to_mem = st_gated;
   assign bus.mem_read        = mem_read_reg;
   assign bus.mem_write       = mem_write_reg;

endmodule

// File: tb/tb_psimd_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_psimd_mem_access_unit
// Bench for psimd_mem_access_unit: a 32-word data memory, a store data
// source, a vector table of directed requests, a reset-abort sequence, a
// held-req_valid sequence and randomized requests. Every cycle of every
// request is compared against a cycle-indexed expectation built from the
// request rules (legality, N beats, N+2 cycle occupancy).
// ---------------------------------------------------------------------------
module tb_psimd_mem_access_unit;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic        pop;
      logic        lv;
      logic [2:0]  lidx;
      logic [63:0] ldata;
      logic        done;
      logic        err;
      logic        rdy;
   } obs_t;

   typedef struct {
      bit          st;
      logic [31:0] addr;
      logic [3:0]  beats;
      bit          exp_err;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   psimd_mem_access_unit_if bus_if ();

   psimd_mem_access_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // ---------------- environment: memory and store source ----------------
   logic [63:0] dmem      [0:31];
   logic [63:0] model_mem [0:31];
   logic        mem_init;
   logic [63:0] st_src    [0:7];
   logic [2:0]  st_ptr = 3'd0;
   int          overlap_cnt = 0;

   assign bus_if.data_in_from_mem = bus_if.mem_read ? dmem[bus_if.address[7:3]] : 64'd0;
   assign bus_if.st_data_in       = st_src[st_ptr];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) dmem[i] <= model_mem[i];
      end else if (bus_if.mem_write) begin
         dmem[bus_if.address[7:3]] <= bus_if.data_out_to_mem;
      end
   end

   always @(posedge clk) begin
      if (bus_if.req_valid && bus_if.req_ready) st_ptr <= 3'd0;
      else if (bus_if.st_data_pop)              st_ptr <= st_ptr + 3'd1;
   end

   always @(posedge clk) begin
      if (!rst && bus_if.mem_read && bus_if.mem_write) overlap_cnt <= overlap_cnt + 1;
      if (!rst) begin
         assert (!(bus_if.mem_read && bus_if.mem_write))
            else $error("FAIL strobe_overlap: mem_read=%b mem_write=%b, required not both high",
                        bus_if.mem_read, bus_if.mem_write);
      end
   end

   // ---------------- bookkeeping ----------------
   int          n_cmp = 0;
   int          n_fail = 0;
   int          txn_no = 0;
   logic [63:0] last_ld;

   function automatic obs_t sample_obs();
      obs_t o;
      o.rd    = bus_if.mem_read;
      o.wr    = bus_if.mem_write;
      o.addr  = bus_if.address;
      o.wdata = bus_if.data_out_to_mem;
      o.pop   = bus_if.st_data_pop;
      o.lv    = bus_if.ld_data_valid;
      o.lidx  = bus_if.ld_data_valid ? bus_if.ld_beat_idx : 3'd0;
      o.ldata = bus_if.ld_data_out;
      o.done  = bus_if.done;
      o.err   = bus_if.error;
      o.rdy   = bus_if.req_ready;
      return o;
   endfunction

   task automatic check_obs(input string tag, input obs_t e);
      obs_t a;
      a = sample_obs();
      n_cmp++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", tag, a, e);
      end
   endtask

   task automatic check_mem(input string tag);
      int bad;
      int first;
      bad = 0;
      first = -1;
      for (int i = 0; i < 32; i++) begin
         if (dmem[i] !== model_mem[i]) begin
            bad++;
            if (first < 0) first = i;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: %0d words differ, word %0d got %h, required %h",
                  tag, bad, first, dmem[first], model_mem[first]);
      end
   endtask

   // One request, called and returning at a negedge. rst_req >= 0 asserts
   // rst during that beat of a legal request.
   task automatic run_req(input bit st, input logic [31:0] a, input logic [3:0] n,
                          input int rst_req, output bit saw_err);
      obs_t   e;
      obs_t   act;
      bit     legal;
      bit     active;
      longint last_byte;
      int     w, ncyc, rst_at, waited;
      string  tag;

      saw_err = 1'b0;
      tag     = $sformatf("txn%0d", txn_no);
      waited  = 0;
      while (!bus_if.req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_cmp++;
      if (!bus_if.req_ready) begin
         n_fail++;
         $display("FAIL %s ready_timeout: req_ready=0 after 20 cycles, required 1", tag);
         txn_no++;
         return;
      end

      for (int i = 0; i < 8; i++) st_src[i] = {$urandom(), $urandom()};

      last_byte = longint'(a) + 8 * (longint'(n) - 1);
      legal  = (a % 8 == 0) && (n >= 1) && (n <= 8) && (last_byte <= 255);
      w      = a / 8;
      rst_at = (legal && rst_req >= 0 && rst_req < int'(n)) ? rst_req : -1;
      ncyc   = (rst_at >= 0) ? rst_at + 3 : (legal ? int'(n) + 2 : 2);

      bus_if.req_is_store = st;
      bus_if.req_addr     = a;
      bus_if.req_beats    = n;
      bus_if.req_valid    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.req_valid    = 1'b0;

      for (int c = 0; c < ncyc; c++) begin
         active = !(rst_at >= 0 && c > rst_at);
         e = '0;
         if (legal) begin
            if (active && c < int'(n)) begin
               e.rd    = !st;
               e.wr    = st;
               e.addr  = a + 32'(8 * c);
               e.pop   = st;
               e.wdata = st ? st_src[c] : 64'd0;
            end
            if (active && !st && c >= 1 && c <= int'(n)) begin
               e.lv    = 1'b1;
               e.lidx  = 3'(c - 1);
               last_ld = model_mem[w + c - 1];
            end
            e.done = active && (c == int'(n));
            e.rdy  = !active || (c > int'(n));
         end else begin
            e.err = (c == 0);
            e.rdy = (c >= 1);
         end
         if (!active) last_ld = 64'd0;
         e.ldata = last_ld;

         act = sample_obs();
         if (act.err) saw_err = 1'b1;
         check_obs($sformatf("%s_c%0d", tag, c), e);

         if (legal && st && active && c < int'(n)) model_mem[w + c] = st_src[c];
         if (rst_at >= 0 && c == rst_at)     rst = 1'b1;
         if (rst_at >= 0 && c == rst_at + 1) rst = 1'b0;
         if (c < ncyc - 1) @(negedge clk);
      end

      $display("txn %0d %s addr=%h beats=%0d legal=%0d rst_at=%0d error_seen=%0d",
               txn_no, st ? "store" : "load ", a, n, legal, rst_at, saw_err);
      txn_no++;
   endtask

   // ---------------- main sequence ----------------
   vec_t vtab [14];

   initial begin
      obs_t        e;
      bit          se;
      int          accepts, last_edge, exp_gap, exp_acc, t6_n;
      logic [31:0] t6_addr;
      logic [31:0] ra;
      logic [3:0]  rb;
      int          rsel, rrst;
      bit          rdy_now;

      vtab[0]  = '{1'b0, 32'h0000_0008, 4'd1, 1'b0};
      vtab[1]  = '{1'b1, 32'h0000_0020, 4'd3, 1'b0};
      vtab[2]  = '{1'b0, 32'h0000_0020, 4'd3, 1'b0};
      vtab[3]  = '{1'b0, 32'h0000_000C, 4'd1, 1'b1};
      vtab[4]  = '{1'b1, 32'h0000_0010, 4'd0, 1'b1};
      vtab[5]  = '{1'b0, 32'h0000_00F8, 4'd2, 1'b1};
      vtab[6]  = '{1'b1, 32'h0000_00F8, 4'd1, 1'b0};
      vtab[7]  = '{1'b0, 32'h0000_0000, 4'd9, 1'b1};
      vtab[8]  = '{1'b0, 32'h0000_0000, 4'd8, 1'b0};
      vtab[9]  = '{1'b1, 32'h0000_00C8, 4'd8, 1'b1};
      vtab[10] = '{1'b1, 32'h0000_00C0, 4'd8, 1'b0};
      vtab[11] = '{1'b0, 32'hFFFF_FFF8, 4'd2, 1'b1};
      vtab[12] = '{1'b0, 32'h0000_00C0, 4'd8, 1'b0};
      vtab[13] = '{1'b1, 32'h0000_0000, 4'd1, 1'b0};

      for (int i = 0; i < 32; i++) model_mem[i] = {$urandom(), $urandom()};
      model_mem[1] = 64'h3e00_3e00_3e00_3e00;
      for (int i = 0; i < 8; i++) st_src[i] = 64'd0;

      rst                 = 1'b1;
      mem_init            = 1'b1;
      bus_if.req_valid    = 1'b0;
      bus_if.req_is_store = 1'b0;
      bus_if.req_addr     = 32'd0;
      bus_if.req_beats    = 4'd0;
      last_ld             = 64'd0;
      repeat (3) @(negedge clk);
      mem_init = 1'b0;

      // reset state, while held and after release
      e = '0;
      e.rdy = 1'b1;
      check_obs("reset_held", e);
      rst = 1'b0;
      @(negedge clk);
      check_obs("reset_released", e);

      // directed vector table
      for (int v = 0; v < 14; v++) begin
         run_req(vtab[v].st, vtab[v].addr, vtab[v].beats, -1, se);
         n_cmp++;
         if (se !== vtab[v].exp_err) begin
            n_fail++;
            $display("FAIL vec%0d_error: got %0d, required %0d", v, se, vtab[v].exp_err);
         end
      end

      // reset during beat 2 of a 5-beat store: only beats 0..2 reach memory
      run_req(1'b1, 32'h0000_0040, 4'd5, 2, se);
      check_mem("mem_after_rst_abort");

      // req_valid held high: accepts only when idle, every N+2 cycles
      t6_n    = 2;
      t6_addr = 32'h0000_0010;
      exp_gap = t6_n + 2;
      exp_acc = (20 + exp_gap - 1) / exp_gap;
      accepts = 0;
      last_edge = -1;
      bus_if.req_is_store = 1'b0;
      bus_if.req_addr     = t6_addr;
      bus_if.req_beats    = 4'(t6_n);
      bus_if.req_valid    = 1'b1;
      for (int edge_no = 0; edge_no < 20; edge_no++) begin
         rdy_now = bus_if.req_ready;
         @(posedge clk);
         if (rdy_now) begin
            if (last_edge >= 0) begin
               n_cmp++;
               if (edge_no - last_edge != exp_gap) begin
                  n_fail++;
                  $display("FAIL held_valid_gap: got %0d cycles, required %0d",
                           edge_no - last_edge, exp_gap);
               end
            end
            last_edge = edge_no;
            accepts++;
         end
         @(negedge clk);
      end
      bus_if.req_valid = 1'b0;
      n_cmp++;
      if (accepts != exp_acc) begin
         n_fail++;
         $display("FAIL held_valid_accepts: got %0d, required %0d", accepts, exp_acc);
      end
      $display("txn %0d held-valid load addr=%h beats=%0d accepts=%0d", txn_no, t6_addr, t6_n, accepts);
      txn_no++;
      last_ld = model_mem[t6_addr / 8 + t6_n - 1];

      // randomized requests
      for (int r = 0; r < 40; r++) begin
         rsel = $urandom_range(0, 9);
         if (rsel < 7)       ra = {24'd0, 5'($urandom_range(0, 31)), 3'b000};
         else if (rsel == 7) ra = {24'd0, 8'($urandom_range(0, 255))};
         else if (rsel == 8) ra = $urandom();
         else                ra = 32'h0000_00F8 - 32'(8 * $urandom_range(0, 3));
         rb   = 4'($urandom_range(0, 9));
         rrst = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
         run_req(1'($urandom_range(0, 1)), ra, rb, rrst, se);
      end

      check_mem("mem_final");
      n_cmp++;
      if (overlap_cnt != 0) begin
         n_fail++;
         $display("FAIL strobe_overlap_count: got %0d, required 0", overlap_cnt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
